cp0_reg: RTL and testbench

//  CP0 system-control register file, downstream of the MEM/WB pipeline register.
//  - Commits mtc0 writes presented on wb_cp0_reg_*.
//  - Runs the Count/Compare timer and samples the hardware interrupt lines.
//  - Records exceptions and eret signalled by the mem-stage exception logic.
//  - Supplies mfc0 read data and the Status/Cause/EPC values used for exception and forwarding decisions.

---
 rtl/cp0_reg_pkg.sv | 39 +++
 rtl/cp0_reg_if.sv | 11 +
 rtl/cp0_reg.sv | 108 ++++++++++
 tb/tb_cp0_reg.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cp0_reg_pkg.sv
// Shared CP0 definitions: register numbers, exception type codes and the
// mapping from mem-stage exception type to the Cause.ExcCode field.
package cp0_reg_pkg;

    localparam logic [4:0] REG_COUNT   = 5'd9;
    localparam logic [4:0] REG_COMPARE = 5'd11;
    localparam logic [4:0] REG_STATUS  = 5'd12;
    localparam logic [4:0] REG_CAUSE   = 5'd13;
    localparam logic [4:0] REG_EPC     = 5'd14;
    localparam logic [4:0] REG_PRID    = 5'd15;
    localparam logic [4:0] REG_CONFIG  = 5'd16;

    localparam logic [31:0] EXC_INTERRUPT = 32'h0000_0001;
    localparam logic [31:0] EXC_SYSCALL   = 32'h0000_0008;
    localparam logic [31:0] EXC_RI        = 32'h0000_000a;
    localparam logic [31:0] EXC_TRAP      = 32'h0000_000d;
    localparam logic [31:0] EXC_OVERFLOW  = 32'h0000_000c;
    localparam logic [31:0] EXC_ERET      = 32'h0000_000e;

    // True for exception types that enter exception level (eret excluded).
    function automatic logic exc_valid_f(input logic [31:0] excepttype);
        case (excepttype)
            EXC_INTERRUPT, EXC_SYSCALL, EXC_RI, EXC_TRAP, EXC_OVERFLOW: exc_valid_f = 1'b1;
            default:                                                    exc_valid_f = 1'b0;
        endcase
    endfunction

    function automatic logic [4:0] exc_code_f(input logic [31:0] excepttype);
        case (excepttype)
            EXC_INTERRUPT: exc_code_f = 5'd0;
            EXC_SYSCALL:   exc_code_f = 5'd8;
            EXC_RI:        exc_code_f = 5'd10;
            EXC_TRAP:      exc_code_f = 5'd13;
            EXC_OVERFLOW:  exc_code_f = 5'd12;
            default:       exc_code_f = 5'd0;
        endcase
    endfunction

endpackage

// File: rtl/cp0_reg_if.sv
// mtc0 write port and mfc0 read port of the CP0 register file.
interface cp0_reg_if;
    logic        we_i;
    logic [4:0]  waddr_i;
    logic [31:0] wdata_i;
    logic [4:0]  raddr_i;
    logic [31:0] data_o;

    modport master (output we_i, output waddr_i, output wdata_i, output raddr_i, input data_o);
    modport slave  (input we_i, input waddr_i, input wdata_i, input raddr_i, output data_o);
endinterface

// File: rtl/cp0_reg.sv
// CP0 system-control register file: mtc0 commit, Count/Compare timer,
// interrupt sampling, exception/eret recording and mfc0 read path.
module cp0_reg
    import cp0_reg_pkg::*;
#(
    parameter logic [31:0] PRID_VAL   = 32'h0048_0102,
    parameter logic [31:0] CONFIG_RST = 32'h0000_8000,
    parameter logic [31:0] STATUS_RST = 32'h1000_0000
) (
    input  logic          clk,
    input  logic          reset,
    cp0_reg_if.slave      bus,
    input  logic [5:0]    int_i,
    input  logic [31:0]   excepttype_i,
    input  logic [31:0]   current_inst_addr_i,
    input  logic          is_in_delayslot_i,
    output logic [31:0]   count_o,
    output logic [31:0]   compare_o,
    output logic [31:0]   status_o,
    output logic [31:0]   cause_o,
    output logic [31:0]   epc_o,
    output logic [31:0]   config_o,
    output logic [31:0]   prid_o,
    output logic          timer_int_o
);

    logic [31:0] count_r;
    logic [31:0] compare_r;
    logic [31:0] status_r;
    logic [31:0] cause_r;
    logic [31:0] epc_r;
    logic [31:0] config_r;
    logic        timer_int_r;

    // Register update; later assignments deliberately override earlier ones
    // (write over increment, Compare clear over match, exception over write).
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r     <= 32'd0;
            compare_r   <= 32'd0;
            status_r    <= STATUS_RST;
            cause_r     <= 32'd0;
            epc_r       <= 32'd0;
            config_r    <= CONFIG_RST;
            timer_int_r <= 1'b0;
        end else begin
            count_r        <= count_r + 32'd1;
            cause_r[15:10] <= int_i;
            if ((compare_r != 32'd0) && (count_r == compare_r)) begin
                timer_int_r <= 1'b1;
            end

            if (bus.we_i) begin
                case (bus.waddr_i)
                    REG_COUNT:   count_r <= bus.wdata_i;
                    REG_COMPARE: begin
                        compare_r   <= bus.wdata_i;
                        timer_int_r <= 1'b0;
                    end
                    REG_STATUS:  status_r <= bus.wdata_i;
                    REG_EPC:     epc_r    <= bus.wdata_i;
                    REG_CAUSE:   begin
                        cause_r[9:8]   <= bus.wdata_i[9:8];
                        cause_r[23:22] <= bus.wdata_i[23:22];
                    end
                    default: ;
                endcase
            end

            // Nested exceptions (EXL already set) keep the original EPC and BD.
            if (excepttype_i == EXC_ERET) begin
                status_r[1] <= 1'b0;
            end else if (exc_valid_f(excepttype_i)) begin
                if (!status_r[1]) begin
                    epc_r       <= is_in_delayslot_i ? (current_inst_addr_i - 32'd4) : current_inst_addr_i;
                    cause_r[31] <= is_in_delayslot_i;
                end
                status_r[1]  <= 1'b1;
                cause_r[6:2] <= exc_code_f(excepttype_i);
            end
        end
    end

    // mfc0 read mux over the implemented registers.
    always_comb begin
        bus.data_o = 32'd0;
        case (bus.raddr_i)
            REG_COUNT:   bus.data_o = count_r;
            REG_COMPARE: bus.data_o = compare_r;
            REG_STATUS:  bus.data_o = status_r;
            REG_CAUSE:   bus.data_o = cause_r;
            REG_EPC:     bus.data_o = epc_r;
            REG_PRID:    bus.data_o = PRID_VAL;
            REG_CONFIG:  bus.data_o = config_r;
            default:     bus.data_o = 32'd0;
        endcase
    end

    assign count_o     = count_r;
    assign compare_o   = compare_r;
    assign status_o    = status_r;
    assign cause_o     = cause_r;
    assign epc_o       = epc_r;
    assign config_o    = config_r;
    assign prid_o      = PRID_VAL;
    assign timer_int_o = timer_int_r;

endmodule

// File: tb/tb_cp0_reg.sv
// Scoreboard bench for cp0_reg: expectations are queued with each stimulus
// and compared against the DUT outputs just after the committing edge.
module tb_cp0_reg;

    localparam int S_COUNT = 0, S_COMPARE = 1, S_STATUS = 2, S_CAUSE = 3, S_EPC = 4,
                   S_CONFIG = 5, S_PRID = 6, S_TIMER = 7, S_DATA = 8;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] exp;
    } sb_item_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  int_i;
    logic [31:0] excepttype_i;
    logic [31:0] current_inst_addr_i;
    logic        is_in_delayslot_i;
    logic [31:0] count_o, compare_o, status_o, cause_o, epc_o, config_o, prid_o;
    logic        timer_int_o;

    int checks_r = 0;
    int errors_r = 0;
    sb_item_t sb_q[$];

    cp0_reg_if bus ();

    cp0_reg dut (
        .clk                 (clk),
        .reset               (reset),
        .bus                 (bus),
        .int_i               (int_i),
        .excepttype_i        (excepttype_i),
        .current_inst_addr_i (current_inst_addr_i),
        .is_in_delayslot_i   (is_in_delayslot_i),
        .count_o             (count_o),
        .compare_o           (compare_o),
        .status_o            (status_o),
        .cause_o             (cause_o),
        .epc_o               (epc_o),
        .config_o            (config_o),
        .prid_o              (prid_o),
        .timer_int_o         (timer_int_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] obs_f(input int sel);
        case (sel)
            S_COUNT:   obs_f = count_o;
            S_COMPARE: obs_f = compare_o;
            S_STATUS:  obs_f = status_o;
            S_CAUSE:   obs_f = cause_o;
            S_EPC:     obs_f = epc_o;
            S_CONFIG:  obs_f = config_o;
            S_PRID:    obs_f = prid_o;
            S_TIMER:   obs_f = {31'd0, timer_int_o};
            S_DATA:    obs_f = bus.data_o;
            default:   obs_f = 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_r++;
        if (obs !== exp) begin
            errors_r++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic expect_val(input string tag, input int sel, input logic [31:0] exp);
        sb_item_t it;
        it.tag = tag;
        it.sel = sel;
        it.exp = exp;
        sb_q.push_back(it);
    endtask

    // One committing edge, then drain the scoreboard against the DUT.
    task automatic step();
        sb_item_t it;
        @(posedge clk);
        #1;
        while (sb_q.size() > 0) begin
            it = sb_q.pop_front();
            check_val(it.tag, obs_f(it.sel), it.exp);
        end
    endtask

    task automatic mtc0(input logic [4:0] addr, input logic [31:0] data);
        bus.we_i    = 1'b1;
        bus.waddr_i = addr;
        bus.wdata_i = data;
    endtask

    task automatic expect_reset_state();
        expect_val("rst_count",   S_COUNT,   32'h0000_0000);
        expect_val("rst_compare", S_COMPARE, 32'h0000_0000);
        expect_val("rst_status",  S_STATUS,  32'h1000_0000);
        expect_val("rst_cause",   S_CAUSE,   32'h0000_0000);
        expect_val("rst_epc",     S_EPC,     32'h0000_0000);
        expect_val("rst_config",  S_CONFIG,  32'h0000_8000);
        expect_val("rst_prid",    S_PRID,    32'h0048_0102);
        expect_val("rst_timer",   S_TIMER,   32'd0);
    endtask

    initial begin
        reset               = 1'b1;
        bus.we_i            = 1'b0;
        bus.waddr_i         = 5'd0;
        bus.wdata_i         = 32'd0;
        bus.raddr_i         = 5'd12;
        int_i               = 6'd0;
        excepttype_i        = 32'd0;
        current_inst_addr_i = 32'd0;
        is_in_delayslot_i   = 1'b0;

        // Reset held two cycles, then count runs 1,2,3
        expect_reset_state();
        step();
        expect_reset_state();
        expect_val("rd_status_rst", S_DATA, 32'h1000_0000);
        step();
        reset = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            expect_val("count_run", S_COUNT, 32'(i));
            step();
        end

        // Timer: Count=0, Compare=5, interrupt after count==5, sticky, cleared by Compare write
        mtc0(5'd9, 32'd0);
        expect_val("count_load0", S_COUNT, 32'd0);
        step();
        mtc0(5'd11, 32'd5);
        expect_val("cmp_count", S_COUNT, 32'd1);
        expect_val("cmp_load", S_COMPARE, 32'd5);
        step();
        bus.we_i = 1'b0;
        for (int i = 2; i <= 5; i++) begin
            expect_val("count_pre_match", S_COUNT, 32'(i));
            expect_val("timer_low", S_TIMER, 32'd0);
            step();
        end
        expect_val("count_match", S_COUNT, 32'd6);
        expect_val("timer_rise", S_TIMER, 32'd1);
        step();
        for (int i = 0; i < 2; i++) begin
            expect_val("timer_sticky", S_TIMER, 32'd1);
            step();
        end
        mtc0(5'd11, 32'd100);
        expect_val("timer_clear", S_TIMER, 32'd0);
        expect_val("cmp_100", S_COMPARE, 32'd100);
        step();

        // Count wrap, write wins over increment
        mtc0(5'd9, 32'hFFFF_FFFE);
        expect_val("count_wr", S_COUNT, 32'hFFFF_FFFE);
        step();
        bus.we_i = 1'b0;
        expect_val("count_max", S_COUNT, 32'hFFFF_FFFF);
        step();
        expect_val("count_wrap", S_COUNT, 32'h0000_0000);
        step();
        expect_val("count_after_wrap", S_COUNT, 32'h0000_0001);
        step();

        // Syscall in delay slot with EXL=0
        excepttype_i = 32'h8; current_inst_addr_i = 32'h100; is_in_delayslot_i = 1'b1;
        expect_val("sys_epc", S_EPC, 32'h0000_00FC);
        expect_val("sys_cause", S_CAUSE, 32'h8000_0020);
        expect_val("sys_status", S_STATUS, 32'h1000_0002);
        step();
        // Nested syscall: EPC and BD kept
        current_inst_addr_i = 32'h200; is_in_delayslot_i = 1'b0;
        expect_val("nest_epc", S_EPC, 32'h0000_00FC);
        expect_val("nest_cause", S_CAUSE, 32'h8000_0020);
        expect_val("nest_status", S_STATUS, 32'h1000_0002);
        step();
        excepttype_i = 32'ha; current_inst_addr_i = 32'h300;
        expect_val("ri_cause", S_CAUSE, 32'h8000_0028);
        expect_val("ri_epc", S_EPC, 32'h0000_00FC);
        step();

        // eret, then mtc0 Status with simultaneous syscall
        excepttype_i = 32'he;
        expect_val("eret_status", S_STATUS, 32'h1000_0000);
        expect_val("eret_epc", S_EPC, 32'h0000_00FC);
        step();
        mtc0(5'd12, 32'h0000_0003);
        excepttype_i = 32'h8; current_inst_addr_i = 32'h400; is_in_delayslot_i = 1'b0;
        expect_val("wr_exc_status", S_STATUS, 32'h0000_0003);
        expect_val("wr_exc_epc", S_EPC, 32'h0000_0400);
        expect_val("wr_exc_cause", S_CAUSE, 32'h0000_0020);
        step();
        bus.we_i = 1'b0;
        excepttype_i = 32'h5;
        expect_val("unlisted_status", S_STATUS, 32'h0000_0003);
        expect_val("unlisted_epc", S_EPC, 32'h0000_0400);
        expect_val("unlisted_cause", S_CAUSE, 32'h0000_0020);
        step();
        excepttype_i = 32'd0;

        // Interrupt sampling and masked Cause write
        int_i = 6'b100001;
        expect_val("cause_ip", S_CAUSE, 32'h0000_8420);
        step();
        mtc0(5'd13, 32'hFFFF_FFFF);
        expect_val("cause_wr", S_CAUSE, 32'h00C0_8720);
        step();

        // Read-only registers and read mux
        mtc0(5'd16, 32'd0);
        bus.raddr_i = 5'd16;
        expect_val("config_ro", S_CONFIG, 32'h0000_8000);
        expect_val("rd_config", S_DATA, 32'h0000_8000);
        step();
        mtc0(5'd15, 32'd0);
        bus.raddr_i = 5'd15;
        expect_val("prid_ro", S_PRID, 32'h0048_0102);
        expect_val("rd_prid", S_DATA, 32'h0048_0102);
        step();
        bus.we_i = 1'b0;
        bus.raddr_i = 5'd13;
        expect_val("rd_cause", S_DATA, 32'h00C0_8720);
        step();
        bus.raddr_i = 5'd3;
        expect_val("rd_unmapped", S_DATA, 32'h0000_0000);
        step();
        bus.raddr_i = 5'd14;
        expect_val("rd_epc", S_DATA, 32'h0000_0400);
        step();
        bus.raddr_i = 5'd11;
        expect_val("rd_compare", S_DATA, 32'd100);
        step();

        // Mid-operation reset discards same-cycle write and exception
        reset = 1'b1;
        int_i = 6'd0;
        mtc0(5'd12, 32'hFFFF_FFFF);
        excepttype_i = 32'h8; current_inst_addr_i = 32'h500;
        expect_reset_state();
        step();
        reset = 1'b0;
        bus.we_i = 1'b0;
        excepttype_i = 32'd0;
        expect_val("post_rst_count", S_COUNT, 32'd1);
        expect_val("post_rst_status", S_STATUS, 32'h1000_0000);
        step();

        $display("CHECKS %0d ERRORS %0d", checks_r, errors_r);
        $finish;
    end

endmodule
